// File: rtl/hazard_unit_if.sv
// Hazard unit interface: groups the pipeline register numbers, stage control
// bits and the stall/flush/forward results. The slave modport is the hazard
// unit itself; the master modport is the pipeline datapath around it.
// Optional performance-counter signals exist only when HAZARD_PERF_EN is defined.
interface hazard_unit_if;
    logic [4:0]  RsD;
    logic [4:0]  RtD;
    logic [4:0]  RsE;
    logic [4:0]  RtE;
    logic [4:0]  WriteRegE;
    logic [4:0]  WriteRegM;
    logic [4:0]  WriteRegW;
    logic        RegWriteE;
    logic        RegWriteM;
    logic        RegWriteW;
    logic        MemToRegE;
    logic        MemToRegM;
    logic        BranchD;
    logic        MemReqM;
    logic        MemReadyM;
    logic        StallF;
    logic        StallD;
    logic        StallE;
    logic        StallM;
    logic        FlushE;
    logic        FlushW;
    logic        ForwardAD;
    logic        ForwardBD;
    logic [1:0]  ForwardAE;
    logic [1:0]  ForwardBE;
    logic        MemErr;
`ifdef HAZARD_PERF_EN
    logic        PerfClr;
    logic [15:0] LdStallCnt;
    logic [15:0] BrStallCnt;
    logic [15:0] MemWaitCnt;
`endif

    modport master (
        output RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW,
        output RegWriteE, RegWriteM, RegWriteW, MemToRegE, MemToRegM, BranchD,
        output MemReqM, MemReadyM,
        input  StallF, StallD, StallE, StallM, FlushE, FlushW,
        input  ForwardAD, ForwardBD, ForwardAE, ForwardBE, MemErr
`ifdef HAZARD_PERF_EN
        , output PerfClr
        , input  LdStallCnt, BrStallCnt, MemWaitCnt
`endif
    );

    modport slave (
        input  RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW,
        input  RegWriteE, RegWriteM, RegWriteW, MemToRegE, MemToRegM, BranchD,
        input  MemReqM, MemReadyM,
        output StallF, StallD, StallE, StallM, FlushE, FlushW,
        output ForwardAD, ForwardBD, ForwardAE, ForwardBE, MemErr
`ifdef HAZARD_PERF_EN
        , input  PerfClr
        , output LdStallCnt, BrStallCnt, MemWaitCnt
`endif
    );
endinterface

// File: rtl/hazard_unit.sv
// Pipeline hazard unit: operand forwarding, load-use and branch stalls, and
// data-memory wait handling with a timeout watchdog (RUN/WAIT/ERR).
// Forward and stall outputs are combinational; MemErr is a registered sticky flag.
// Optional macro HAZARD_PERF_EN adds three saturating 16-bit stall counters.
module hazard_unit (
    input  logic         CLK,
    input  logic         rst_n,
    hazard_unit_if.slave hz
);
    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_WAIT = 2'd1,
        ST_ERR  = 2'd2
    } state_t;

    state_t     r_state;
    logic [7:0] r_wcnt;
    logic       r_mem_err;

    logic       w_lwstall;
    logic       w_brstall;
    logic       w_memstall;
    logic       w_dstall;

    // Hazard conditions; register 0 is hard-wired and never creates a dependency
    always_comb begin
        w_lwstall  = hz.MemToRegE && (hz.RtE != 5'd0) &&
                     ((hz.RtE == hz.RsD) || (hz.RtE == hz.RtD));
        w_brstall  = hz.BranchD &&
                     ((hz.RegWriteE && (hz.WriteRegE != 5'd0) &&
                       ((hz.WriteRegE == hz.RsD) || (hz.WriteRegE == hz.RtD))) ||
                      (hz.MemToRegM && (hz.WriteRegM != 5'd0) &&
                       ((hz.WriteRegM == hz.RsD) || (hz.WriteRegM == hz.RtD))));
        w_memstall = hz.MemReqM && !hz.MemReadyM;
        w_dstall   = w_lwstall || w_brstall;
    end

    // Execute-stage ALU operand forwarding; the younger M result beats W
    always_comb begin
        hz.ForwardAE = 2'b00;
        hz.ForwardBE = 2'b00;
        if ((hz.RsE != 5'd0) && hz.RegWriteM && (hz.RsE == hz.WriteRegM)) begin
            hz.ForwardAE = 2'b10;
        end else if ((hz.RsE != 5'd0) && hz.RegWriteW && (hz.RsE == hz.WriteRegW)) begin
            hz.ForwardAE = 2'b01;
        end else begin
            hz.ForwardAE = 2'b00;
        end
        if ((hz.RtE != 5'd0) && hz.RegWriteM && (hz.RtE == hz.WriteRegM)) begin
            hz.ForwardBE = 2'b10;
        end else if ((hz.RtE != 5'd0) && hz.RegWriteW && (hz.RtE == hz.WriteRegW)) begin
            hz.ForwardBE = 2'b01;
        end else begin
            hz.ForwardBE = 2'b00;
        end
    end

    // Decode-stage branch comparator forwarding from M
    always_comb begin
        hz.ForwardAD = (hz.RsD != 5'd0) && hz.RegWriteM && (hz.RsD == hz.WriteRegM);
        hz.ForwardBD = (hz.RtD != 5'd0) && hz.RegWriteM && (hz.RtD == hz.WriteRegM);
    end

    // Stall/flush steering: a memory wait freezes the whole pipe and overrides
    // decode hazards, otherwise decode hazards hold F/D and bubble E
    always_comb begin
        hz.StallF = 1'b0;
        hz.StallD = 1'b0;
        hz.StallE = 1'b0;
        hz.StallM = 1'b0;
        hz.FlushE = 1'b0;
        hz.FlushW = 1'b0;
        if (w_memstall) begin
            hz.StallF = 1'b1;
            hz.StallD = 1'b1;
            hz.StallE = 1'b1;
            hz.StallM = 1'b1;
            hz.FlushE = 1'b0;
            hz.FlushW = 1'b1;
        end else begin
            hz.StallF = w_dstall;
            hz.StallD = w_dstall;
            hz.FlushE = w_dstall;
        end
    end

    // Memory-wait watchdog: counts unready cycles, latches an error after 256
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_RUN;
            r_wcnt    <= 8'd0;
            r_mem_err <= 1'b0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (w_memstall) begin
                        r_state <= ST_WAIT;
                        r_wcnt  <= 8'd1;
                    end else begin
                        r_wcnt  <= 8'd0;
                    end
                end
                ST_WAIT: begin
                    if (hz.MemReadyM) begin
                        r_state <= ST_RUN;
                        r_wcnt  <= 8'd0;
                    end else if (w_memstall && (r_wcnt == 8'd255)) begin
                        r_state   <= ST_ERR;
                        r_mem_err <= 1'b1;
                    end else begin
                        r_wcnt <= r_wcnt + 8'd1;
                    end
                end
                ST_ERR: begin
                    r_mem_err <= 1'b1;
                end
                default: begin
                    r_state   <= ST_RUN;
                    r_wcnt    <= 8'd0;
                    r_mem_err <= 1'b0;
                end
            endcase
        end
    end

    assign hz.MemErr = r_mem_err;

`ifdef HAZARD_PERF_EN
    logic [15:0] r_ld_cnt;
    logic [15:0] r_br_cnt;
    logic [15:0] r_mw_cnt;

    // Saturating increment so a long-running count never wraps to a small value
    function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic en);
        if (en && (v != 16'hFFFF)) begin
            return v + 16'd1;
        end else begin
            return v;
        end
    endfunction

    // Stall-cause counters; clear wins over increment
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            r_ld_cnt <= 16'd0;
            r_br_cnt <= 16'd0;
            r_mw_cnt <= 16'd0;
        end else if (hz.PerfClr) begin
            r_ld_cnt <= 16'd0;
            r_br_cnt <= 16'd0;
            r_mw_cnt <= 16'd0;
        end else begin
            r_ld_cnt <= sat_inc(r_ld_cnt, w_lwstall && !w_memstall);
            r_br_cnt <= sat_inc(r_br_cnt, w_brstall && !w_memstall);
            r_mw_cnt <= sat_inc(r_mw_cnt, w_memstall);
        end
    end

    assign hz.LdStallCnt = r_ld_cnt;
    assign hz.BrStallCnt = r_br_cnt;
    assign hz.MemWaitCnt = r_mw_cnt;
`endif
endmodule

// File: tb/tb_hazard_unit.sv
// Directed self-checking bench for hazard_unit. Expected values are pushed to
// a scoreboard queue when stimulus is applied and popped at each check point.
// Stall bundle = {StallF,StallD,StallE,StallM,FlushE,FlushW};
// forward bundle = {ForwardAD,ForwardBD,ForwardAE,ForwardBE}.
module tb_hazard_unit;
    logic clk;
    logic rst_n;

    hazard_unit_if hz_if ();

    hazard_unit u_dut (
        .CLK   (clk),
        .rst_n (rst_n),
        .hz    (hz_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    wire [5:0] w_stall = {hz_if.StallF, hz_if.StallD, hz_if.StallE,
                          hz_if.StallM, hz_if.FlushE, hz_if.FlushW};
    wire [5:0] w_fwd   = {hz_if.ForwardAD, hz_if.ForwardBD,
                          hz_if.ForwardAE, hz_if.ForwardBE};

    logic [31:0] exp_q[$];
    int n_vec = 0;
    int n_err = 0;

    task automatic push(input logic [31:0] e);
        exp_q.push_back(e);
    endtask

    task automatic check(input string tag, input logic [31:0] obs);
        logic [31:0] e;
        n_vec++;
        if (exp_q.size() == 0) begin
            n_err++;
            $error("FAIL %s scoreboard empty observed=%0h", tag, obs);
        end else begin
            e = exp_q.pop_front();
            assert (obs === e) else begin
                n_err++;
                $error("FAIL %s observed=%0h expected=%0h", tag, obs, e);
            end
        end
    endtask

    task automatic clear_in();
        hz_if.RsD = 5'd0; hz_if.RtD = 5'd0; hz_if.RsE = 5'd0; hz_if.RtE = 5'd0;
        hz_if.WriteRegE = 5'd0; hz_if.WriteRegM = 5'd0; hz_if.WriteRegW = 5'd0;
        hz_if.RegWriteE = 1'b0; hz_if.RegWriteM = 1'b0; hz_if.RegWriteW = 1'b0;
        hz_if.MemToRegE = 1'b0; hz_if.MemToRegM = 1'b0; hz_if.BranchD = 1'b0;
        hz_if.MemReqM = 1'b0; hz_if.MemReadyM = 1'b0;
`ifdef HAZARD_PERF_EN
        hz_if.PerfClr = 1'b0;
`endif
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        #1 rst_n = 1'b0;
        #3 rst_n = 1'b1;
        cycles(1);
    endtask

    initial begin
        rst_n = 1'b0;
        clear_in();
        #2;
        // reset state
        push(32'd0); check("reset_memerr", {31'd0, hz_if.MemErr});
        push(32'd0); check("reset_stall", {26'd0, w_stall});
        push(32'd0); check("reset_fwd", {26'd0, w_fwd});
        cycles(1);
        rst_n = 1'b1;
        cycles(1);

        // forwarding: M beats W
        hz_if.RsE = 5'd5; hz_if.WriteRegM = 5'd5; hz_if.RegWriteM = 1'b1;
        hz_if.WriteRegW = 5'd5; hz_if.RegWriteW = 1'b1;
        push(32'h08); #1 check("fwd_ae_m", {26'd0, w_fwd});
        hz_if.RsE = 5'd0;
        push(32'h00); #1 check("fwd_rse_zero", {26'd0, w_fwd});
        hz_if.RsE = 5'd5; hz_if.RtE = 5'd5; hz_if.RegWriteM = 1'b0;
        push(32'h05); #1 check("fwd_w_only", {26'd0, w_fwd});
        hz_if.RsD = 5'd9; hz_if.RtD = 5'd5; hz_if.WriteRegM = 5'd9; hz_if.RegWriteM = 1'b1;
        hz_if.RsE = 5'd9; hz_if.RtE = 5'd5;
        push(32'h29); #1 check("fwd_mixed", {26'd0, w_fwd});
        push(32'h00); check("fwd_no_stall", {26'd0, w_stall});
        hz_if.RegWriteM = 1'b0;
        push(32'h01); #1 check("fwd_m_disabled", {26'd0, w_fwd});

        // load-use stall
        clear_in();
        hz_if.MemToRegE = 1'b1; hz_if.RtE = 5'd8; hz_if.RsD = 5'd8;
        push(32'h32); #1 check("lw_rsd", {26'd0, w_stall});
        hz_if.RtE = 5'd0; hz_if.RsD = 5'd0;
        push(32'h00); #1 check("lw_r0", {26'd0, w_stall});
        hz_if.RtE = 5'd8; hz_if.RsD = 5'd1; hz_if.RtD = 5'd8;
        push(32'h32); #1 check("lw_rtd", {26'd0, w_stall});
        hz_if.RsD = 5'd3; hz_if.RtD = 5'd4;
        push(32'h00); #1 check("lw_nodep", {26'd0, w_stall});

        // branch stalls and memory-wait override
        clear_in();
        hz_if.BranchD = 1'b1; hz_if.RegWriteE = 1'b1; hz_if.WriteRegE = 5'd3; hz_if.RtD = 5'd3;
        push(32'h32); #1 check("br_e", {26'd0, w_stall});
        hz_if.MemReqM = 1'b1; hz_if.MemReadyM = 1'b0;
        push(32'h3D); #1 check("br_memstall", {26'd0, w_stall});
        hz_if.MemReadyM = 1'b1;
        push(32'h32); #1 check("br_memready", {26'd0, w_stall});
        hz_if.BranchD = 1'b0;
        push(32'h00); #1 check("nobranch", {26'd0, w_stall});
        clear_in();
        hz_if.BranchD = 1'b1; hz_if.MemToRegM = 1'b1; hz_if.WriteRegM = 5'd4; hz_if.RsD = 5'd4;
        push(32'h32); #1 check("br_m_load", {26'd0, w_stall});
        hz_if.WriteRegM = 5'd0; hz_if.RsD = 5'd0;
        push(32'h00); #1 check("br_m_r0", {26'd0, w_stall});

        // watchdog: 255 unready cycles then ready -> no error
        clear_in();
        do_reset();
        hz_if.MemReqM = 1'b1; hz_if.MemReadyM = 1'b0;
        cycles(255);
        push(32'd0); check("wait255_memerr", {31'd0, hz_if.MemErr});
        hz_if.MemReadyM = 1'b1;
        cycles(3);
        push(32'd0); check("wait255_ready", {31'd0, hz_if.MemErr});

        // watchdog: 256 unready cycles -> sticky error
        clear_in();
        do_reset();
        hz_if.MemReqM = 1'b1; hz_if.MemReadyM = 1'b0;
        cycles(255);
        push(32'd0); check("err_before", {31'd0, hz_if.MemErr});
        cycles(1);
        push(32'd1); check("err_set", {31'd0, hz_if.MemErr});
        push(32'h3D); check("err_stall", {26'd0, w_stall});
        hz_if.MemReadyM = 1'b1;
        cycles(5);
        push(32'd1); check("err_sticky", {31'd0, hz_if.MemErr});
        push(32'h00); check("err_released", {26'd0, w_stall});
        rst_n = 1'b0;
        #1;
        push(32'd0); check("err_async_clr", {31'd0, hz_if.MemErr});
        #2 rst_n = 1'b1;
        cycles(1);

        // reset mid-wait abandons the count
        hz_if.MemReqM = 1'b1; hz_if.MemReadyM = 1'b0;
        cycles(100);
        rst_n = 1'b0;
        #1;
        push(32'h3D); check("rst_comb_stall", {26'd0, w_stall});
        push(32'd0); check("rst_mid_wait", {31'd0, hz_if.MemErr});
        #2 rst_n = 1'b1;
        cycles(200);
        push(32'd0); check("rst_wcnt_clear", {31'd0, hz_if.MemErr});
        hz_if.MemReadyM = 1'b1;
        cycles(2);

`ifdef HAZARD_PERF_EN
        clear_in();
        do_reset();
        push(32'd0); check("perf_reset", {16'd0, hz_if.LdStallCnt});
        hz_if.MemToRegE = 1'b1; hz_if.RtE = 5'd8; hz_if.RsD = 5'd8;
        cycles(3);
        push(32'd3); check("perf_ld3", {16'd0, hz_if.LdStallCnt});
        cycles(69997);
        push(32'h0000FFFF); check("perf_ld_sat", {16'd0, hz_if.LdStallCnt});
        push(32'd0); check("perf_br_idle", {16'd0, hz_if.BrStallCnt});
        push(32'd0); check("perf_mw_idle", {16'd0, hz_if.MemWaitCnt});
        hz_if.PerfClr = 1'b1;
        cycles(1);
        push(32'd0); check("perf_clr", {16'd0, hz_if.LdStallCnt});
        hz_if.PerfClr = 1'b0;
        clear_in();
        hz_if.MemReqM = 1'b1; hz_if.MemToRegE = 1'b1; hz_if.RtE = 5'd8; hz_if.RsD = 5'd8;
        cycles(4);
        push(32'd4); check("perf_mw4", {16'd0, hz_if.MemWaitCnt});
        push(32'd0); check("perf_ld_masked", {16'd0, hz_if.LdStallCnt});
        clear_in();
`endif

        if (exp_q.size() != 0) begin
            n_err++;
            $error("FAIL scoreboard_leftover observed=%0d expected=0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/hazard_unit.md
HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 SHALL have ports: CLK  in  1  pipeline clock; all state updates on rising edge.
REQ-002 SHALL have ports: rst_n  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have ports: RsD, RtD  in  5 each  decode-stage source register numbers.
REQ-004 SHALL have ports: RsE, RtE, WriteRegE  in  5 each  execute-stage sources and destination.
REQ-005 SHALL have ports: WriteRegM, WriteRegW  in  5 each  memory- and writeback-stage destinations.
REQ-006 SHALL have ports: RegWriteE, RegWriteM, RegWriteW, MemToRegE, MemToRegM, BranchD  in  1 each  stage control bits.
REQ-007 SHALL have ports: MemReqM  in  1  data-memory access in M; MemReadyM  in  1  data memory completes this cycle.
REQ-008 SHALL have ports: StallF, StallD, StallE, StallM  out  1 each  hold the PC and the D/E/M pipeline registers.
REQ-009 SHALL have ports: FlushE  out  1  drives the execute-register CLR (bubble into E); FlushW  out  1  bubble into W.
REQ-010 SHALL have ports: ForwardAD, ForwardBD  out  1 each  branch-compare forward from M; ForwardAE, ForwardBE  out  2 each  ALU operand select.
REQ-011 SHALL have ports: MemErr  out  1  sticky memory-timeout flag.
REQ-012 SHALL have ports, only with HAZARD_PERF_EN: PerfClr  in  1; LdStallCnt, BrStallCnt, MemWaitCnt  out  16 each.

Function
REQ-013 ForwardAE SHALL be 2'b10 if RsE!=0, RegWriteM, RsE==WriteRegM; else 2'b01 if RsE!=0, RegWriteW, RsE==WriteRegW; else 2'b00 (M wins over W); ForwardBE identical using RtE.
REQ-014 ForwardAD SHALL be 1 iff RsD!=0, RegWriteM, RsD==WriteRegM; ForwardBD likewise with RtD.
REQ-015 lwstall SHALL be MemToRegE & RtE!=0 & (RtE==RsD | RtE==RtD).
REQ-016 brstall SHALL be BranchD & ((RegWriteE & WriteRegE!=0 & WriteRegE in {RsD,RtD}) | (MemToRegM & WriteRegM!=0 & WriteRegM in {RsD,RtD})).
REQ-017 memstall SHALL be MemReqM & ~MemReadyM, combinational, same cycle.
REQ-018 With memstall: StallF=StallD=StallE=StallM=1, FlushW=1, FlushE=0; lwstall/brstall SHALL be ignored that cycle.
REQ-019 Without memstall: StallF=StallD=FlushE=(lwstall|brstall); StallE=StallM=FlushW=0.
REQ-020 Forward outputs SHALL be purely combinational, zero latency, unaffected by stalls.
REQ-021 FSM states SHALL be RUN, WAIT, ERR, with 8-bit wait counter WCnt.
REQ-022 RUN: memstall -> WAIT, WCnt=1; else stay, WCnt=0.
REQ-023 WAIT: MemReadyM -> RUN, WCnt=0; else WCnt+1; on WCnt==255 with memstall still high -> ERR.
REQ-024 ERR: MemErr=1, stays until reset; stall outputs still follow REQ-017..019 (no forced release).
REQ-025 MemErr SHALL be registered: first high the cycle after entering ERR.

Reset
REQ-026 On rst_n low, asynchronously: FSM=RUN, WCnt=0, MemErr=0, all perf counters 0.
REQ-027 Combinational outputs SHALL depend only on inputs during reset; reset mid-WAIT SHALL abandon the wait with no error.

Configuration
REQ-028 Macro HAZARD_PERF_EN defined: three 16-bit saturating counters (hold at 16'hFFFF) increment per cycle of lwstall&~memstall, brstall&~memstall, memstall respectively; PerfClr synchronously zeroes all, taking priority over increment.
REQ-029 HAZARD_PERF_EN undefined: PerfClr and counter ports and logic SHALL be absent; all other behaviour identical.

Verification
REQ-030 RsE=5, WriteRegM=5, RegWriteM=1, WriteRegW=5, RegWriteW=1 -> ForwardAE=2'b10; RsE=0 with same -> 2'b00.
REQ-031 MemToRegE=1, RtE=8, RsD=8 -> StallF=StallD=FlushE=1, StallE=0; RtE=0 -> no stall.
REQ-032 BranchD=1, RegWriteE=1, WriteRegE=3, RtD=3 -> FlushE=1; same plus MemReqM=1, MemReadyM=0 -> FlushE=0, StallE=StallM=FlushW=1.
REQ-033 MemReqM=1, MemReadyM=0 for 255 cycles then ready -> FSM RUN, MemErr=0; 256 cycles unready -> MemErr=1 next edge, persists after MemReadyM=1 until rst_n.
REQ-034 rst_n low mid-WAIT at WCnt=100 -> WCnt=0, FSM RUN immediately; with HAZARD_PERF_EN, 70000 lwstall cycles -> LdStallCnt=16'hFFFF, PerfClr -> 0 next edge.
